// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and default parameter values for the pipeline
//               stall/flush sequencer (pipe_ctrl) and its counter.
//               Contents:
//                 pipe_state_e   - sequencer state encoding
//                 STALL_W_DEF    - default stall counter width
//                 KILL_DEPTH_DEF - default front-end flush length
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HZ   = 2'd1,
        KILL = 2'd2,
        MDU  = 2'd3
    } pipe_state_e;

    localparam int STALL_W_DEF    = 2;
    localparam int KILL_DEPTH_DEF = 2;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_cnt
// Description : Loadable down-counter that stops at zero (never wraps).
//               Load has priority over decrement.
// Ports       : clk   - clock
//               nrst  - asynchronous active-low reset (count -> 0)
//               load  - load val into the counter
//               val   - load value
//               dec   - decrement by one when the count is nonzero
//               zero  - count == 0
//               one   - count == 1
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [WIDTH-1:0] val,
    input  logic             dec,
    output logic             zero,
    output logic             one
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);
    assign one  = (r_cnt == WIDTH'(1));

endmodule : pipe_ctrl_cnt
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Stall/flush sequencer for the 5-stage in-order core
//               (F, D, X, M, W). Turns hazard, branch, multi-cycle-unit and
//               memory-wait conditions into stage enables, bubble strobes and
//               front-end flushes. All cycle counting lives here.
//               Optional build macro: PIPE_CTRL_PERF_EN enables the two
//               saturating performance counters; otherwise they read 0.
// Ports       : clk, nrst            - clock, async active-low reset
//               hz_stall/hz_stallnum - RAW stall request and its length
//               btaken               - branch/jump taken in X
//               mdu_busy             - multi-cycle unit holding X
//               mem_wait             - data memory not ready for M
//               en_f..en_w           - stage register enables
//               bubble_x, bubble_m   - inject NOP into X / M
//               flush_f, flush_d     - invalidate F / D
//               kill                 - suppress scoreboard write allocation
//               state_o              - current state (debug)
//               perf_stall_cycles    - stall cycle count (optional)
//               perf_kill_cycles     - kill cycle count (optional)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int KILL_DEPTH = KILL_DEPTH_DEF,
    parameter int STALL_W    = STALL_W_DEF
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               hz_stall,
    input  logic [STALL_W-1:0] hz_stallnum,
    input  logic               btaken,
    input  logic               mdu_busy,
    input  logic               mem_wait,
    output logic               en_f,
    output logic               en_d,
    output logic               en_x,
    output logic               en_m,
    output logic               en_w,
    output logic               bubble_x,
    output logic               bubble_m,
    output logic               flush_f,
    output logic               flush_d,
    output logic               kill,
    output logic [1:0]         state_o,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_kill_cycles
);

    // KILL_DEPTH is 1..3, so the kill counter needs at most two bits.
    localparam int               c_KILL_W    = 2;
    localparam logic [c_KILL_W-1:0] c_KILL_LOAD = c_KILL_W'(KILL_DEPTH - 1);
    localparam pipe_state_e      c_KILL_NEXT = (KILL_DEPTH > 1) ? KILL : RUN;

    pipe_state_e r_state;
    pipe_state_e w_next;

    logic [4:0]         w_en;        // {f, d, x, m, w}
    logic               w_bubble_x;
    logic               w_bubble_m;
    logic               w_flush;
    logic               w_kill;
    logic               w_stall_load;
    logic [STALL_W-1:0] w_stall_val;
    logic               w_stall_dec;
    logic               w_stall_zero;
    logic               w_stall_one;
    logic               w_kill_load;
    logic               w_kill_dec;
    logic               w_kill_zero;
    logic               w_kill_one;
    logic               w_run_path;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    pipe_ctrl_cnt #(
        .WIDTH (STALL_W)
    ) u_stall_cnt (
        .clk  (clk),
        .nrst (nrst),
        .load (w_stall_load),
        .val  (w_stall_val),
        .dec  (w_stall_dec),
        .zero (w_stall_zero),
        .one  (w_stall_one)
    );

    pipe_ctrl_cnt #(
        .WIDTH (c_KILL_W)
    ) u_kill_cnt (
        .clk  (clk),
        .nrst (nrst),
        .load (w_kill_load),
        .val  (c_KILL_LOAD),
        .dec  (w_kill_dec),
        .zero (w_kill_zero),
        .one  (w_kill_one)
    );

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    // The cycle mdu_busy drops behaves like RUN: X is released, so a hazard
    // or branch presented in that same cycle must be handled right away.
    assign w_run_path = (r_state == RUN) || ((r_state == MDU) && !mdu_busy);

    always_comb begin
        w_next       = r_state;
        w_en         = 5'b11111;
        w_bubble_x   = 1'b0;
        w_bubble_m   = 1'b0;
        w_flush      = 1'b0;
        w_kill       = 1'b0;
        w_stall_load = 1'b0;
        w_stall_val  = '0;
        w_stall_dec  = 1'b0;
        w_kill_load  = 1'b0;
        w_kill_dec   = 1'b0;

        if (mem_wait) begin
            // Whole pipe frozen; X is held so other events re-present later.
            w_en = 5'b00000;
        end else if (btaken && !((r_state == MDU) && mdu_busy)) begin
            // Taken branch: flush the front end and drop any pending stall.
            w_flush      = 1'b1;
            w_kill       = 1'b1;
            w_kill_load  = 1'b1;
            w_stall_load = 1'b1;
            w_stall_val  = '0;
            w_next       = c_KILL_NEXT;
        end else begin
            unique case (r_state)
                HZ: begin
                    w_en        = 5'b00111;
                    w_bubble_x  = 1'b1;
                    w_stall_dec = 1'b1;
                    if (w_stall_one || w_stall_zero) begin
                        w_next = RUN;
                    end
                end
                KILL: begin
                    // D holds a killed instruction, so hz_stall is ignored.
                    w_flush    = 1'b1;
                    w_kill     = 1'b1;
                    w_kill_dec = 1'b1;
                    if (w_kill_one || w_kill_zero) begin
                        w_next = RUN;
                    end
                end
                default: begin
                    if ((r_state == MDU) && mdu_busy) begin
                        w_en       = 5'b00011;
                        w_bubble_m = 1'b1;
                    end else if (w_run_path && hz_stall) begin
                        w_en       = 5'b00111;
                        w_bubble_x = 1'b1;
                        // A stall length of 0 counts as a single cycle.
                        if (hz_stallnum > STALL_W'(1)) begin
                            w_stall_load = 1'b1;
                            w_stall_val  = hz_stallnum - 1'b1;
                            w_next       = HZ;
                        end else begin
                            w_next = RUN;
                        end
                    end else if (w_run_path && mdu_busy) begin
                        w_en       = 5'b00011;
                        w_bubble_m = 1'b1;
                        w_next     = MDU;
                    end else begin
                        w_next = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: while in reset the pipe is held and the front end flushed.
    // ------------------------------------------------------------------
    assign en_f     = nrst & w_en[4];
    assign en_d     = nrst & w_en[3];
    assign en_x     = nrst & w_en[2];
    assign en_m     = nrst & w_en[1];
    assign en_w     = nrst & w_en[0];
    assign bubble_x = nrst & w_bubble_x;
    assign bubble_m = nrst & w_bubble_m;
    assign flush_f  = ~nrst | w_flush;
    assign flush_d  = ~nrst | w_flush;
    assign kill     = ~nrst | w_kill;
    assign state_o  = r_state;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_kill;

    // Flops are in reset whenever nrst is low, so the ungated strobes are
    // sufficient here.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_perf_stall <= '0;
            r_perf_kill  <= '0;
        end else begin
            if ((w_bubble_x || w_bubble_m || mem_wait) && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_kill && (r_perf_kill != '1)) begin
                r_perf_kill <= r_perf_kill + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_kill_cycles  = r_perf_kill;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_kill_cycles  = 32'd0;
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl (KILL_DEPTH=2, STALL_W=2).
//               Stimulus pushes a hand-computed expected output word per
//               cycle; a monitor pops and compares on the falling edge.
//               Word layout: [11:10] state, [9:5] en_f..en_w, [4] bubble_x,
//               [3] bubble_m, [2] flush_f, [1] flush_d, [0] kill.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        nrst;
    logic        hz_stall;
    logic [1:0]  hz_stallnum;
    logic        btaken;
    logic        mdu_busy;
    logic        mem_wait;
    logic        en_f, en_d, en_x, en_m, en_w;
    logic        bubble_x, bubble_m;
    logic        flush_f, flush_d;
    logic        kill;
    logic [1:0]  state_o;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_kill_cycles;

    int errors = 0;
    int checks = 0;

    logic [11:0] q_exp[$];
    string       q_name[$];
    int          exp_perf_stall = 0;
    int          exp_perf_kill  = 0;

    localparam logic [11:0] E_RESET    = {2'd0, 5'b00000, 2'b00, 2'b11, 1'b1};
    localparam logic [11:0] E_IDLE     = {2'd0, 5'b11111, 2'b00, 2'b00, 1'b0};
    localparam logic [11:0] E_HZ_RUN   = {2'd0, 5'b00111, 2'b10, 2'b00, 1'b0};
    localparam logic [11:0] E_HZ       = {2'd1, 5'b00111, 2'b10, 2'b00, 1'b0};
    localparam logic [11:0] E_BT_RUN   = {2'd0, 5'b11111, 2'b00, 2'b11, 1'b1};
    localparam logic [11:0] E_BT_HZ    = {2'd1, 5'b11111, 2'b00, 2'b11, 1'b1};
    localparam logic [11:0] E_KILL     = {2'd2, 5'b11111, 2'b00, 2'b11, 1'b1};
    localparam logic [11:0] E_MDU_RUN  = {2'd0, 5'b00011, 2'b01, 2'b00, 1'b0};
    localparam logic [11:0] E_MDU      = {2'd3, 5'b00011, 2'b01, 2'b00, 1'b0};
    localparam logic [11:0] E_MDU_FALL = {2'd3, 5'b11111, 2'b00, 2'b00, 1'b0};
    localparam logic [11:0] E_WAIT_RUN = {2'd0, 5'b00000, 2'b00, 2'b00, 1'b0};
    localparam logic [11:0] E_WAIT_HZ  = {2'd1, 5'b00000, 2'b00, 2'b00, 1'b0};

    pipe_ctrl #(
        .KILL_DEPTH (2),
        .STALL_W    (2)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .hz_stall          (hz_stall),
        .hz_stallnum       (hz_stallnum),
        .btaken            (btaken),
        .mdu_busy          (mdu_busy),
        .mem_wait          (mem_wait),
        .en_f              (en_f),
        .en_d              (en_d),
        .en_x              (en_x),
        .en_m              (en_m),
        .en_w              (en_w),
        .bubble_x          (bubble_x),
        .bubble_m          (bubble_m),
        .flush_f           (flush_f),
        .flush_d           (flush_d),
        .kill              (kill),
        .state_o           (state_o),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_kill_cycles  (perf_kill_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    initial begin
        logic [11:0] act;
        logic [11:0] exp;
        string       nm;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                exp = q_exp.pop_front();
                nm  = q_name.pop_front();
                act = {state_o, en_f, en_d, en_x, en_m, en_w,
                       bubble_x, bubble_m, flush_f, flush_d, kill};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL %s: got %b required %b", nm, act, exp);
                end
            end
        end
    end

    // Apply one cycle of inputs and queue the expected response.
    task automatic step(input string nm, input logic hs, input logic [1:0] hn,
                        input logic bt, input logic mdu, input logic mw,
                        input logic [11:0] exp);
        hz_stall    = hs;
        hz_stallnum = hn;
        btaken      = bt;
        mdu_busy    = mdu;
        mem_wait    = mw;
        q_exp.push_back(exp);
        q_name.push_back(nm);
        if (exp[4] || exp[3] || mw) exp_perf_stall++;
        if (exp[0]) exp_perf_kill++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ps;
        int exp_pk;
        int guard;
        nrst        = 1'b0;
        hz_stall    = 1'b0;
        hz_stallnum = 2'd0;
        btaken      = 1'b0;
        mdu_busy    = 1'b0;
        mem_wait    = 1'b0;

        // Reset-time outputs.
        q_exp.push_back(E_RESET);
        q_name.push_back("reset_outputs");
        @(posedge clk);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        step("idle_after_reset", 0, 2'd0, 0, 0, 0, E_IDLE);

        // Three-cycle hazard stall.
        step("hz3_c1",   1, 2'd3, 0, 0, 0, E_HZ_RUN);
        step("hz3_c2",   0, 2'd0, 0, 0, 0, E_HZ);
        step("hz3_c3",   1, 2'd1, 0, 0, 0, E_HZ);
        step("hz3_done", 0, 2'd0, 0, 0, 0, E_IDLE);

        // Stall length 0 and 1 both give a single bubble.
        step("hz0",      1, 2'd0, 0, 0, 0, E_HZ_RUN);
        step("hz0_done", 0, 2'd0, 0, 0, 0, E_IDLE);
        step("hz1",      1, 2'd1, 0, 0, 0, E_HZ_RUN);
        step("hz1_done", 0, 2'd0, 0, 0, 0, E_IDLE);

        // Taken branch, hazard ignored during the kill cycle.
        step("bt_c1",    0, 2'd0, 1, 0, 0, E_BT_RUN);
        step("bt_c2_hz", 1, 2'd2, 0, 0, 0, E_KILL);
        step("bt_done",  0, 2'd0, 0, 0, 0, E_IDLE);

        // Branch aborts a hazard stall on its second cycle.
        step("abort_c1",   1, 2'd3, 0, 0, 0, E_HZ_RUN);
        step("abort_bt",   0, 2'd0, 1, 0, 0, E_BT_HZ);
        step("abort_kill", 0, 2'd0, 0, 0, 0, E_KILL);
        step("abort_done", 0, 2'd0, 0, 0, 0, E_IDLE);

        // Memory wait during HZ with stall_cnt=2, branch ignored while frozen.
        step("mw_hz_c1", 1, 2'd3, 0, 0, 0, E_HZ_RUN);
        step("mw_w1",    0, 2'd0, 0, 0, 1, E_WAIT_HZ);
        step("mw_w2",    0, 2'd0, 1, 0, 1, E_WAIT_HZ);
        step("mw_w3",    1, 2'd3, 0, 1, 1, E_WAIT_HZ);
        step("mw_w4",    0, 2'd0, 0, 0, 1, E_WAIT_HZ);
        step("mw_hz_r1", 0, 2'd0, 0, 0, 0, E_HZ);
        step("mw_hz_r2", 0, 2'd0, 0, 0, 0, E_HZ);
        step("mw_done",  0, 2'd0, 0, 0, 0, E_IDLE);

        // Multi-cycle unit busy for five cycles.
        step("mdu_c1",   0, 2'd0, 0, 1, 0, E_MDU_RUN);
        for (int i = 0; i < 4; i++) begin
            step("mdu_hold", 0, 2'd0, 0, 1, 0, E_MDU);
        end
        step("mdu_fall", 0, 2'd0, 0, 0, 0, E_MDU_FALL);
        step("mdu_done", 0, 2'd0, 0, 0, 0, E_IDLE);

        // Second branch during KILL reloads the kill count.
        step("bt2_c1",   0, 2'd0, 1, 0, 0, E_BT_RUN);
        step("bt2_c2",   0, 2'd0, 1, 0, 0, E_KILL);
        step("bt2_c3",   0, 2'd0, 0, 0, 0, E_KILL);
        step("bt2_done", 0, 2'd0, 0, 0, 0, E_IDLE);

        // Memory wait in RUN overrides a taken branch.
        step("mw_run_bt", 0, 2'd0, 1, 0, 1, E_WAIT_RUN);
        step("mw_run_done", 0, 2'd0, 0, 0, 0, E_IDLE);

        // Let the monitor drain the queue, bounded.
        guard = 0;
        while (q_exp.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q_exp.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d responses left unchecked, required 0", q_exp.size());
        end

        // Performance counters.
`ifdef PIPE_CTRL_PERF_EN
        exp_ps = exp_perf_stall;
        exp_pk = exp_perf_kill;
`else
        exp_ps = 0;
        exp_pk = 0;
`endif
        checks++;
        if (perf_stall_cycles !== 32'(exp_ps)) begin
            errors++;
            $display("FAIL perf_stall: got %0d required %0d", perf_stall_cycles, exp_ps);
        end
        checks++;
        if (perf_kill_cycles !== 32'(exp_pk)) begin
            errors++;
            $display("FAIL perf_kill: got %0d required %0d", perf_kill_cycles, exp_pk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_ctrl
`default_nettype wire
